// File: rtl/count_display_driver.sv
// Samples a 7-bit count, converts it to BCD with a sequential double-dabble engine, and
// multiplexes the two digits onto a common-anode 7-segment display. A separate divider
// turns the buzzer request level into a square-wave tone.
module count_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned TONE_DIV    = 12500,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [6:0] Count,
  input  logic       buz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       ovf,
  output logic       buzzer_out
);

  localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ToneW = $clog2(TONE_DIV + 1);
  localparam logic [RefW-1:0]  RefMax  = RefW'(REFRESH_DIV - 1);
  localparam logic [ToneW-1:0] ToneMax = ToneW'(TONE_DIV);

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'h3F;

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e      state_q, state_d;
  logic [6:0]  sh_q, sh_d;
  // Scratch is {hundreds bit, tens nibble, ones nibble}; a 7-bit input never exceeds 1xx.
  logic [8:0]  bcd_q, bcd_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic        ovf_q, ovf_d;
  logic        valid_q, valid_d;
  logic [RefW-1:0]  refresh_q, refresh_d;
  logic             digit_sel_q, digit_sel_d;
  logic [ToneW-1:0] tone_q, tone_d;
  logic             buzzer_q, buzzer_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  an_q, an_d;
  logic [3:0]  tens_adj, ones_adj;

  function automatic logic [6:0] decode(input logic [3:0] digit);
    logic [6:0] pat;
    unique case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

  // Conversion FSM: capture, seven add-3/shift steps, then publish to the display regs.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    ones_adj  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    unique case (state_q)
      StIdle: begin
        sh_d      = Count;
        bcd_d     = '0;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        bcd_d     = {tens_adj, ones_adj, sh_q[6]};
        sh_d      = {sh_q[5:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd6) state_d = StLoad;
      end
      StLoad: begin
        ones_d  = bcd_q[3:0];
        tens_d  = bcd_q[7:4];
        ovf_d   = bcd_q[8];
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Refresh divider: digit slot flips when the counter wraps.
  always_comb begin
    refresh_d   = refresh_q + 1'b1;
    digit_sel_d = digit_sel_q;
    if (refresh_q == RefMax) begin
      refresh_d   = '0;
      digit_sel_d = ~digit_sel_q;
    end
  end

  // Segment/anode selection from next-state values so a LOAD reaches the pins on its own edge.
  always_comb begin
    seg_d = SegBlank;
    an_d  = 2'b11;
    if (valid_d) begin
      if (!digit_sel_d) begin
        an_d  = 2'b10;
        seg_d = ovf_d ? SegDash : decode(ones_d);
      end else if (ovf_d) begin
        an_d  = 2'b01;
        seg_d = SegDash;
      end else if (!(BLANK_LZ && (tens_d == 4'd0))) begin
        an_d  = 2'b01;
        seg_d = decode(tens_d);
      end
    end
  end

  // Tone divider: counter runs 1..TONE_DIV while buz is high, 0 parks it when idle.
  always_comb begin
    tone_d   = '0;
    buzzer_d = 1'b0;
    if (buz) begin
      buzzer_d = buzzer_q;
      if (tone_q == ToneMax) begin
        tone_d   = ToneW'(1);
        buzzer_d = ~buzzer_q;
      end else begin
        tone_d = tone_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      tens_q      <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      refresh_q   <= '0;
      digit_sel_q <= 1'b0;
      tone_q      <= '0;
      buzzer_q    <= 1'b0;
      seg_q       <= SegBlank;
      an_q        <= 2'b11;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      refresh_q   <= refresh_d;
      digit_sel_q <= digit_sel_d;
      tone_q      <= tone_d;
      buzzer_q    <= buzzer_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign ovf        = ovf_q;
  assign buzzer_out = buzzer_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver (REFRESH_DIV=4, TONE_DIV=3, BLANK_LZ=1).
module tb_count_display_driver;

  logic       Clk = 1'b0;
  logic       reset;
  logic [6:0] Count;
  logic       buz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       ovf;
  logic       buzzer_out;

  int checks   = 0;
  int failures = 0;

  count_display_driver #(
    .REFRESH_DIV(4),
    .TONE_DIV   (3),
    .BLANK_LZ   (1'b1)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .Count     (Count),
    .buz       (buz),
    .seg       (seg),
    .an        (an),
    .ovf       (ovf),
    .buzzer_out(buzzer_out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [6:0] count;
    logic [6:0] ones_seg;
    logic [1:0] tens_an;
    logic [6:0] tens_seg;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Release lands on a negedge so the next posedge is clock 1 after release.
  task automatic do_reset();
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] ones_seg, tens_seg;
    logic [1:0] tens_an;
    int         ones_cnt;

    vecs[0] = '{7'd42,  7'h24, 2'b01, 7'h19, 1'b0};
    vecs[1] = '{7'd5,   7'h12, 2'b11, 7'h7F, 1'b0};
    vecs[2] = '{7'd120, 7'h3F, 2'b01, 7'h3F, 1'b1};
    vecs[3] = '{7'd99,  7'h10, 2'b01, 7'h10, 1'b0};
    vecs[4] = '{7'd0,   7'h40, 2'b11, 7'h7F, 1'b0};
    vecs[5] = '{7'd10,  7'h40, 2'b01, 7'h79, 1'b0};
    vecs[6] = '{7'd127, 7'h3F, 2'b01, 7'h3F, 1'b1};
    vecs[7] = '{7'd100, 7'h3F, 2'b01, 7'h3F, 1'b1};
    vecs[8] = '{7'd68,  7'h00, 2'b01, 7'h02, 1'b0};
    vecs[9] = '{7'd73,  7'h30, 2'b01, 7'h78, 1'b0};

    reset = 1'b1;
    Count = 7'd0;
    buz   = 1'b0;
    #12;
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'h3);
    chk("reset_ovf", 32'(ovf), 32'h0);
    chk("reset_buzzer", 32'(buzzer_out), 32'h0);

    // Latency from release: blank for 8 clocks, ones slot valid on clock 9, tens on clock 12.
    Count = 7'd42;
    do_reset();
    for (int i = 1; i <= 8; i++) tick();
    chk("lat_blank_an", 32'(an), 32'h3);
    chk("lat_blank_seg", 32'(seg), 32'h7F);
    tick();
    chk("lat_ones_an", 32'(an), 32'h2);
    chk("lat_ones_seg", 32'(seg), 32'h24);
    chk("lat_ovf", 32'(ovf), 32'h0);
    for (int i = 10; i <= 12; i++) tick();
    chk("lat_tens_an", 32'(an), 32'h1);
    chk("lat_tens_seg", 32'(seg), 32'h19);

    // Table: settle two conversions, then observe one full 8-clock mux period.
    for (int v = 0; v < 10; v++) begin
      Count = vecs[v].count;
      for (int i = 0; i < 20; i++) tick();
      ones_cnt = 0;
      ones_seg = 7'h55;
      tens_seg = 7'h55;
      tens_an  = 2'b00;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (an == 2'b10) begin
          ones_cnt++;
          ones_seg = seg;
        end else begin
          tens_an  = an;
          tens_seg = seg;
        end
      end
      chk($sformatf("v%0d_ovf", vecs[v].count), 32'(ovf), 32'(vecs[v].ovf));
      chk($sformatf("v%0d_ones_slots", vecs[v].count), 32'(ones_cnt), 32'd4);
      chk($sformatf("v%0d_ones_seg", vecs[v].count), 32'(ones_seg), 32'(vecs[v].ones_seg));
      chk($sformatf("v%0d_tens_an", vecs[v].count), 32'(tens_an), 32'(vecs[v].tens_an));
      chk($sformatf("v%0d_tens_seg", vecs[v].count), 32'(tens_seg), 32'(vecs[v].tens_seg));
    end

    // Overflow then recovery: change lands in IDLE after clock 9, cleared at clock 18.
    Count = 7'd120;
    do_reset();
    for (int i = 1; i <= 9; i++) tick();
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_dash_ones", 32'(seg), 32'h3F);
    Count = 7'd99;
    for (int i = 10; i <= 17; i++) tick();
    chk("ovf_hold", 32'(ovf), 32'h1);
    tick();
    chk("ovf_clear", 32'(ovf), 32'h0);
    chk("ovf_clear_seg", 32'(seg), 32'h10);
    tick();
    tick();
    chk("ovf_clear_tens_an", 32'(an), 32'h1);
    chk("ovf_clear_tens_seg", 32'(seg), 32'h10);

    // Count changes during the third SHIFT cycle: next LOAD shows 42, the one after shows 17.
    Count = 7'd42;
    do_reset();
    for (int i = 1; i <= 3; i++) tick();
    Count = 7'd17;
    for (int i = 4; i <= 9; i++) tick();
    chk("mid_first_an", 32'(an), 32'h2);
    chk("mid_first_seg", 32'(seg), 32'h24);
    for (int i = 10; i <= 17; i++) tick();
    chk("mid_hold_seg", 32'(seg), 32'h24);
    tick();
    chk("mid_second_seg", 32'(seg), 32'h78);
    for (int i = 19; i <= 20; i++) tick();
    chk("mid_second_tens", 32'(seg), 32'h79);

    // Tone: first edge seeing buz is k=0; toggles after edges k=3,6,9,...
    buz = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("tone_k%0d", k), 32'(buzzer_out), 32'((k / 3) % 2));
    end
    buz = 1'b0;
    tick();
    chk("tone_off", 32'(buzzer_out), 32'h0);
    buz = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("tone2_k%0d", k), 32'(buzzer_out), 32'((k / 3) % 2));
    end
    buz = 1'b0;
    tick();
    chk("tone2_off", 32'(buzzer_out), 32'h0);
    tick();
    chk("tone2_stay_off", 32'(buzzer_out), 32'h0);

    // Async reset mid-SHIFT and mid-tone with an overflowed display showing.
    Count = 7'd120;
    buz   = 1'b1;
    do_reset();
    for (int i = 1; i <= 12; i++) tick();
    chk("pre_rst_ovf", 32'(ovf), 32'h1);
    chk("pre_rst_an", 32'(an), 32'h1);
    chk("pre_rst_buzzer", 32'(buzzer_out), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_an", 32'(an), 32'h3);
    chk("async_ovf", 32'(ovf), 32'h0);
    chk("async_buzzer", 32'(buzzer_out), 32'h0);
    buz   = 1'b0;
    Count = 7'd42;
    @(negedge Clk);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    chk("post_rst_blank", 32'(an), 32'h3);
    tick();
    chk("post_rst_an", 32'(an), 32'h2);
    chk("post_rst_seg", 32'(seg), 32'h24);
    chk("post_rst_ovf", 32'(ovf), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
